// File: rtl/lif_array_if.sv
// lif_array_if: step, config and counter signals between a driver and the lif_array neuron block.
interface lif_array_if #(
    parameter int N_CH = 4,
    parameter int W    = 8,
    parameter int RW   = 3
) ();
    logic              en;
    logic [N_CH*W-1:0] cur_in;
    logic              cfg_we;
    logic [W-1:0]      cfg_thresh;
    logic [2:0]        cfg_leak;
    logic [RW-1:0]     cfg_refrac;
    logic              cnt_clr;
    logic [N_CH*W-1:0] state_out;
    logic [N_CH-1:0]   spike;
    logic [15:0]       spike_cnt;
    modport master (
        output en, cur_in, cfg_we, cfg_thresh, cfg_leak, cfg_refrac, cnt_clr,
        input  state_out, spike, spike_cnt
    );
    modport slave (
        input  en, cur_in, cfg_we, cfg_thresh, cfg_leak, cfg_refrac, cnt_clr,
        output state_out, spike, spike_cnt
    );
endinterface

// File: rtl/lif_array.sv
// lif_array: N_CH independent leaky integrate-and-fire neurons with shared config and a saturating spike counter.
module lif_array #(
    parameter int N_CH       = 4,
    parameter int W          = 8,
    parameter int RW         = 3,
    parameter int THRESH_RST = 200,
    parameter int LEAK_RST   = 0,
    parameter int REFRAC_RST = 0
) (
    input logic       clk,
    input logic       rst,
    lif_array_if.slave bus
);
    logic [W-1:0]    thresh_q, thresh_d;
    logic [2:0]      leak_q, leak_d;
    logic [RW-1:0]   refrac_q, refrac_d;
    logic [W-1:0]    state_q [N_CH];
    logic [W-1:0]    state_d [N_CH];
    logic [RW-1:0]   ref_q [N_CH];
    logic [RW-1:0]   ref_d [N_CH];
    logic [N_CH-1:0] spike_q, spike_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [W:0]      sum [N_CH];
    logic [W-1:0]    sat [N_CH];
    logic [N_CH-1:0] fire;
    logic [16:0]     cnt_sum;
    // Neuron math reads the registered config, so a same-edge write only takes effect next step.
    always_comb begin
        thresh_d = bus.cfg_we ? bus.cfg_thresh : thresh_q;
        leak_d   = bus.cfg_we ? bus.cfg_leak : leak_q;
        refrac_d = bus.cfg_we ? bus.cfg_refrac : refrac_q;
        cnt_sum  = {1'b0, cnt_q};
        for (int i = 0; i < N_CH; i++) begin
            sum[i]     = {1'b0, state_q[i]} - ((leak_q == 3'd0) ? '0 : ({1'b0, state_q[i]} >> leak_q))
                         + {1'b0, bus.cur_in[i*W +: W]};
            sat[i]     = sum[i][W] ? '1 : sum[i][W-1:0];
            fire[i]    = (thresh_q != '0) && (sat[i] >= thresh_q);
            state_d[i] = !bus.en ? state_q[i] : ((ref_q[i] != '0) || fire[i]) ? '0 : sat[i];
            ref_d[i]   = !bus.en ? ref_q[i] : (ref_q[i] != '0) ? ref_q[i] - 1'b1 : fire[i] ? refrac_q : '0;
            spike_d[i] = bus.en && (ref_q[i] == '0) && fire[i];
            cnt_sum    = cnt_sum + 17'(spike_d[i]);
        end
        cnt_d = bus.cnt_clr ? '0 : cnt_sum[16] ? '1 : cnt_sum[15:0];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            thresh_q <= W'(THRESH_RST);
            leak_q   <= 3'(LEAK_RST);
            refrac_q <= RW'(REFRAC_RST);
            spike_q  <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= '0;
                ref_q[i]   <= '0;
            end
        end else begin
            thresh_q <= thresh_d;
            leak_q   <= leak_d;
            refrac_q <= refrac_d;
            spike_q  <= spike_d;
            cnt_q    <= cnt_d;
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
                ref_q[i]   <= ref_d[i];
            end
        end
    end
    for (genvar g = 0; g < N_CH; g++) begin : g_out
        assign bus.state_out[g*W +: W] = state_q[g];
    end
    assign bus.spike     = spike_q;
    assign bus.spike_cnt = cnt_q;
endmodule

// File: tb/tb_lif_array.sv
// tb_lif_array: directed stimulus with a scoreboard of hand-derived expected outputs for lif_array.
module tb_lif_array;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    lif_array_if #(.N_CH(4), .W(8), .RW(3)) bus ();
    lif_array #(.N_CH(4), .W(8), .RW(3)) dut (.clk(clk), .rst(rst), .bus(bus));
    typedef struct {
        string       tag;
        logic [31:0] st;
        logic [3:0]  sp;
        logic [15:0] cnt;
    } exp_t;
    exp_t sb[$];
    int tests = 0;
    int fails = 0;
    logic [15:0] ec;
    function automatic logic [31:0] p(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        return {d, c, b, a};
    endfunction
    task automatic step(input string tag, input logic [31:0] st, input logic [3:0] sp, input logic [15:0] cnt);
        exp_t e;
        e.tag = tag;
        e.st  = st;
        e.sp  = sp;
        e.cnt = cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        tests++;
        assert (bus.state_out === e.st) else begin
            fails++;
            $error("FAIL %s state_out got %h exp %h", e.tag, bus.state_out, e.st);
        end
        tests++;
        assert (bus.spike === e.sp) else begin
            fails++;
            $error("FAIL %s spike got %b exp %b", e.tag, bus.spike, e.sp);
        end
        tests++;
        assert (bus.spike_cnt === e.cnt) else begin
            fails++;
            $error("FAIL %s spike_cnt got %h exp %h", e.tag, bus.spike_cnt, e.cnt);
        end
    endtask
    initial begin
        rst = 1'b1;
        bus.en = 1'b0;
        bus.cur_in = '0;
        bus.cfg_we = 1'b0;
        bus.cfg_thresh = 8'd200;
        bus.cfg_leak = 3'd0;
        bus.cfg_refrac = 3'd0;
        bus.cnt_clr = 1'b0;
        step("rst0", 32'h0, 4'h0, 16'h0);
        step("rst1", 32'h0, 4'h0, 16'h0);
        rst = 1'b0;
        // default config: ch0 integrates 50 per step, fires at 200
        bus.en = 1'b1;
        bus.cur_in = p(50, 0, 0, 0);
        step("acc50", p(50, 0, 0, 0), 4'h0, 16'd0);
        step("acc100", p(100, 0, 0, 0), 4'h0, 16'd0);
        step("acc150", p(150, 0, 0, 0), 4'h0, 16'd0);
        step("fire200", p(0, 0, 0, 0), 4'h1, 16'd1);
        bus.en = 1'b0;
        step("pulse_end", p(0, 0, 0, 0), 4'h0, 16'd1);
        // refractory length 2
        bus.cfg_we = 1'b1;
        bus.cfg_refrac = 3'd2;
        step("cfg_ref2", p(0, 0, 0, 0), 4'h0, 16'd1);
        bus.cfg_we = 1'b0;
        bus.en = 1'b1;
        bus.cur_in = p(100, 0, 0, 0);
        step("ref_e1", p(100, 0, 0, 0), 4'h0, 16'd1);
        step("ref_e2", p(0, 0, 0, 0), 4'h1, 16'd2);
        step("ref_e3", p(0, 0, 0, 0), 4'h0, 16'd2);
        step("ref_e4", p(0, 0, 0, 0), 4'h0, 16'd2);
        step("ref_e5", p(100, 0, 0, 0), 4'h0, 16'd2);
        step("ref_e6", p(0, 0, 0, 0), 4'h1, 16'd3);
        // reset mid-refractory with a competing config write
        rst = 1'b1;
        bus.cfg_we = 1'b1;
        bus.cfg_thresh = 8'd5;
        bus.cfg_leak = 3'd3;
        bus.cfg_refrac = 3'd7;
        step("rst_mid", p(0, 0, 0, 0), 4'h0, 16'd0);
        rst = 1'b0;
        bus.cfg_we = 1'b0;
        step("post_rst1", p(100, 0, 0, 0), 4'h0, 16'd0);
        step("post_rst2", p(0, 0, 0, 0), 4'h1, 16'd1);
        step("post_rst3", p(100, 0, 0, 0), 4'h0, 16'd1);
        bus.en = 1'b0;
        bus.cnt_clr = 1'b1;
        step("clr", p(100, 0, 0, 0), 4'h0, 16'd0);
        bus.cnt_clr = 1'b0;
        // firing disabled, saturation at 255
        bus.cfg_we = 1'b1;
        bus.cfg_thresh = 8'd0;
        bus.cfg_leak = 3'd0;
        bus.cfg_refrac = 3'd0;
        step("cfg_th0", p(100, 0, 0, 0), 4'h0, 16'd0);
        bus.cfg_we = 1'b0;
        bus.en = 1'b1;
        bus.cur_in = p(255, 255, 255, 255);
        step("sat1", p(255, 255, 255, 255), 4'h0, 16'd0);
        step("sat2", p(255, 255, 255, 255), 4'h0, 16'd0);
        // new config written this edge must not apply until next edge
        bus.cfg_we = 1'b1;
        bus.cfg_thresh = 8'd255;
        bus.cfg_leak = 3'd1;
        bus.cur_in = '0;
        step("cfg_old", p(255, 255, 255, 255), 4'h0, 16'd0);
        bus.cfg_we = 1'b0;
        step("leak128", p(128, 128, 128, 128), 4'h0, 16'd0);
        step("leak64", p(64, 64, 64, 64), 4'h0, 16'd0);
        step("leak32", p(32, 32, 32, 32), 4'h0, 16'd0);
        step("leak16", p(16, 16, 16, 16), 4'h0, 16'd0);
        bus.en = 1'b0;
        bus.cur_in = p(200, 200, 200, 200);
        for (int i = 0; i < 3; i++) step("en0_hold", p(16, 16, 16, 16), 4'h0, 16'd0);
        // every channel fires every step
        bus.cfg_we = 1'b1;
        bus.cfg_thresh = 8'd1;
        bus.cfg_leak = 3'd0;
        bus.cfg_refrac = 3'd0;
        step("cfg_th1", p(16, 16, 16, 16), 4'h0, 16'd0);
        bus.cfg_we = 1'b0;
        bus.en = 1'b1;
        bus.cur_in = p(1, 1, 1, 1);
        step("all_fire1", 32'h0, 4'hF, 16'd4);
        step("all_fire2", 32'h0, 4'hF, 16'd8);
        bus.cnt_clr = 1'b1;
        step("clr_prio", 32'h0, 4'hF, 16'd0);
        bus.cnt_clr = 1'b0;
        step("after_clr", 32'h0, 4'hF, 16'd4);
        ec = 16'd4;
        while (ec != 16'hFFFF) begin
            ec = (ec > 16'hFFFB) ? 16'hFFFF : ec + 16'd4;
            step("cnt_ramp", 32'h0, 4'hF, ec);
        end
        for (int i = 0; i < 3; i++) step("cnt_stick", 32'h0, 4'hF, 16'hFFFF);
        bus.en = 1'b0;
        bus.cnt_clr = 1'b1;
        step("clr_sat", 32'h0, 4'h0, 16'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
